// File: rtl/mem_pkg.sv
// mem_pkg: request/grant/valid memory interface types plus the SRAM
// adapter additions (ECC width, adapter FSM states, error codes).
//   mem_h2d_t - requester -> memory: req, we, addr (word), data, mask
//   mem_d2h_t - memory -> requester: gnt, valid, data, error
package mem_pkg;

  typedef struct packed {
    logic                          req;
    logic                          we;
    logic [top_pkg::MEM_AW-1:0]    addr;
    logic [top_pkg::MEM_DW-1:0]    data;
    logic [top_pkg::MEM_DBW-1:0]   mask;
  } mem_h2d_t;

  typedef struct packed {
    logic                          gnt;
    logic                          valid;
    logic [top_pkg::MEM_DW-1:0]    data;
    logic [1:0]                    error;
  } mem_d2h_t;

  localparam int MemEccW = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } mem_sram_state_e;

  // error[1] = uncorrectable, error[0] = correctable
  localparam logic [1:0] MEM_ERR_NONE   = 2'b00;
  localparam logic [1:0] MEM_ERR_CORR   = 2'b01;
  localparam logic [1:0] MEM_ERR_UNCORR = 2'b10;

  // Byte enables to a per-bit write mask.
  function automatic logic [top_pkg::MEM_DW-1:0] expand_mask(
    input logic [top_pkg::MEM_DBW-1:0] mask
  );
    logic [top_pkg::MEM_DW-1:0] bits;
    for (int i = 0; i < top_pkg::MEM_DBW; i++) begin
      bits[i*8 +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage : mem_pkg

// File: rtl/top_pkg.sv
// top_pkg: bus geometry shared by the memory interface.
//   MEM_AW  - word-address width of the memory request
//   MEM_DW  - data width of one memory word
//   MEM_DBW - number of byte enables per word
package top_pkg;

  localparam int MEM_AW  = 32;
  localparam int MEM_DW  = 32;
  localparam int MEM_DBW = MEM_DW / 8;

endpackage : top_pkg

// File: rtl/mem_secded_39_32.sv
// mem_secded_39_32: combinational (39,32) SECDED encoder plus decoder.
// Compiled only when MEM_SRAM_ADAPTER_ECC_EN is defined.
// Codeword layout: [31:0] data, [37:32] Hamming checks, [38] overall parity.
// Data bit i sits at Hamming position data_pos(i), the i-th non-power-of-two
// position starting at 3, so a single-bit syndrome names its bit directly.
//   data_i     - data to encode          code_o     - encoded codeword
//   code_i     - codeword to decode      data_o     - corrected data
//   syndrome_o - {overall, hamming[5:0]} err_o      - [1] uncorr, [0] corr
`ifdef MEM_SRAM_ADAPTER_ECC_EN
module mem_secded_39_32 (
  input  logic [31:0] data_i,
  output logic [38:0] code_o,
  input  logic [38:0] code_i,
  output logic [31:0] data_o,
  output logic [6:0]  syndrome_o,
  output logic [1:0]  err_o
);

  function automatic int data_pos(input int idx);
    int cnt;
    cnt = 0;
    for (int p = 3; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) return p;
        cnt++;
      end
    end
    return 0;
  endfunction

  function automatic logic [31:0] chk_mask(input int j);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = ((data_pos(i) >> j) & 1) != 0;
    end
    return m;
  endfunction

  logic [5:0] enc_chk;
  logic [5:0] dec_chk;
  logic [5:0] ham_syn;
  logic       overall;

  for (genvar gi = 0; gi < 6; gi++) begin : g_chk
    localparam logic [31:0] ChkMask = chk_mask(gi);
    assign enc_chk[gi] = ^(data_i & ChkMask);
    assign dec_chk[gi] = ^(code_i[31:0] & ChkMask);
  end

  assign code_o = {^{data_i, enc_chk}, enc_chk, data_i};

  assign ham_syn    = code_i[37:32] ^ dec_chk;
  assign overall    = ^code_i;
  assign syndrome_o = {overall, ham_syn};

  // Odd overall parity means a single flip (possibly in a check bit);
  // even parity with a non-zero syndrome means two flips.
  always_comb begin
    err_o = 2'b00;
    if (overall) begin
      err_o = 2'b01;
    end else if (ham_syn != 6'd0) begin
      err_o = 2'b10;
    end
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_fix
    localparam logic [5:0] Pos = 6'(data_pos(gi));
    assign data_o[gi] = code_i[gi] ^ (overall && (ham_syn == Pos));
  end

endmodule : mem_secded_39_32
`endif

// File: rtl/mem_sram_adapter.sv
// mem_sram_adapter: memory-side responder for the mem_pkg req/gnt/valid
// interface driving a single-port synchronous SRAM macro. One in-order
// response per accepted request, one cycle after the grant (two cycles for
// ECC partial writes, which read-modify-write the word).
// Optional feature macro: MEM_SRAM_ADAPTER_ECC_EN (SECDED (39,32) per word).
//   clk_i, rst_i           - clock, asynchronous active-high reset
//   mem_i / mem_o          - request in / grant + response out
//   sram_req_o, sram_we_o  - macro strobe and write enable
//   sram_addr_o            - macro word index
//   sram_wdata_o/_wmask_o  - macro write codeword and per-bit mask
//   sram_rdata_i           - macro read data, one cycle after a read strobe
module mem_sram_adapter
  import mem_pkg::*;
#(
  parameter int  Depth = 4096,
  localparam int IdxW  = $clog2(Depth),
`ifdef MEM_SRAM_ADAPTER_ECC_EN
  localparam int SramW = top_pkg::MEM_DW + MemEccW
`else
  localparam int SramW = top_pkg::MEM_DW
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  mem_h2d_t         mem_i,
  output mem_d2h_t         mem_o,
  output logic             sram_req_o,
  output logic             sram_we_o,
  output logic [IdxW-1:0]  sram_addr_o,
  output logic [SramW-1:0] sram_wdata_o,
  output logic [SramW-1:0] sram_wmask_o,
  input  logic [SramW-1:0] sram_rdata_i
);

  localparam int DW  = top_pkg::MEM_DW;
  localparam int DBW = top_pkg::MEM_DBW;
  localparam logic [top_pkg::MEM_AW-1:0] DepthA = Depth;

  logic          gnt;
  logic          in_range;
  logic          rsp_valid_reg, rsp_valid_next;
  logic          rsp_read_reg,  rsp_read_next;
  logic [1:0]    rsp_err_reg,   rsp_err_next;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_err;

  assign in_range = mem_i.addr < DepthA;

`ifdef MEM_SRAM_ADAPTER_ECC_EN
  mem_sram_state_e state_reg, state_next;
  logic [IdxW-1:0] rmw_addr_reg, rmw_addr_next;
  logic [DW-1:0]   rmw_data_reg, rmw_data_next;
  logic [DBW-1:0]  rmw_mask_reg, rmw_mask_next;
  logic [DW-1:0]   merged;
  logic [DW-1:0]   enc_data;
  logic [SramW-1:0] enc_code;

  // Decode path: macro read data, used by read responses and the RMW merge.
  mem_secded_39_32 u_dec (
    .data_i     ('0),
    .code_o     (),
    .code_i     (sram_rdata_i),
    .data_o     (rd_data),
    .syndrome_o (),
    .err_o      (rd_err)
  );

  // Encode path: request data for full writes, merged word during RMW.
  mem_secded_39_32 u_enc (
    .data_i     (enc_data),
    .code_o     (enc_code),
    .code_i     ('0),
    .data_o     (),
    .syndrome_o (),
    .err_o      ()
  );

  for (genvar gi = 0; gi < DBW; gi++) begin : g_merge
    assign merged[gi*8 +: 8] = rmw_mask_reg[gi] ? rmw_data_reg[gi*8 +: 8]
                                                : rd_data[gi*8 +: 8];
  end
`else
  assign rd_data = sram_rdata_i;
  assign rd_err  = MEM_ERR_NONE;
`endif

  always_comb begin
    gnt            = 1'b0;
    sram_req_o     = 1'b0;
    sram_we_o      = 1'b0;
    sram_addr_o    = '0;
    sram_wdata_o   = '0;
    sram_wmask_o   = '0;
    rsp_valid_next = 1'b0;
    rsp_read_next  = 1'b0;
    rsp_err_next   = MEM_ERR_NONE;
`ifdef MEM_SRAM_ADAPTER_ECC_EN
    state_next     = state_reg;
    rmw_addr_next  = rmw_addr_reg;
    rmw_data_next  = rmw_data_reg;
    rmw_mask_next  = rmw_mask_reg;
    enc_data       = mem_i.data;
`endif
    if (!rst_i) begin
`ifdef MEM_SRAM_ADAPTER_ECC_EN
      sram_wmask_o = '1;
      if (state_reg == RMW) begin
        // Read data for the word is on sram_rdata_i this cycle.
        enc_data       = merged;
        rsp_valid_next = 1'b1;
        state_next     = IDLE;
        if (rd_err[1]) begin
          rsp_err_next = MEM_ERR_UNCORR;
        end else begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = rmw_addr_reg;
          sram_wdata_o = enc_code;
          rsp_err_next = rd_err;
        end
      end else
`endif
      begin
        gnt = 1'b1;
        if (mem_i.req) begin
          if (!in_range) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = MEM_ERR_UNCORR;
          end else begin
            sram_req_o  = 1'b1;
            sram_addr_o = mem_i.addr[IdxW-1:0];
            if (mem_i.we) begin
`ifdef MEM_SRAM_ADAPTER_ECC_EN
              if (mem_i.mask != '1) begin
                // Read the word now; merge and write next cycle.
                rmw_addr_next = mem_i.addr[IdxW-1:0];
                rmw_data_next = mem_i.data;
                rmw_mask_next = mem_i.mask;
                state_next    = RMW;
              end else begin
                sram_we_o      = 1'b1;
                sram_wdata_o   = enc_code;
                rsp_valid_next = 1'b1;
              end
`else
              sram_we_o      = 1'b1;
              sram_wdata_o   = mem_i.data;
              sram_wmask_o   = expand_mask(mem_i.mask);
              rsp_valid_next = 1'b1;
`endif
            end else begin
              rsp_read_next  = 1'b1;
              rsp_valid_next = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_reg <= 1'b0;
      rsp_read_reg  <= 1'b0;
      rsp_err_reg   <= MEM_ERR_NONE;
`ifdef MEM_SRAM_ADAPTER_ECC_EN
      state_reg     <= IDLE;
      rmw_addr_reg  <= '0;
      rmw_data_reg  <= '0;
      rmw_mask_reg  <= '0;
`endif
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_read_reg  <= rsp_read_next;
      rsp_err_reg   <= rsp_err_next;
`ifdef MEM_SRAM_ADAPTER_ECC_EN
      state_reg     <= state_next;
      rmw_addr_reg  <= rmw_addr_next;
      rmw_data_reg  <= rmw_data_next;
      rmw_mask_reg  <= rmw_mask_next;
`endif
    end
  end

  // Read responses decode the macro output in the response cycle.
  always_comb begin
    mem_o.gnt   = gnt;
    mem_o.valid = rsp_valid_reg;
    mem_o.data  = rsp_read_reg ? rd_data : '0;
    mem_o.error = rsp_err_reg | (rsp_read_reg ? rd_err : MEM_ERR_NONE);
  end

endmodule : mem_sram_adapter

// File: tb/tb_mem_sram_adapter.sv
module tb_mem_sram_adapter;
  import mem_pkg::*;

  localparam int Depth = 4096;
  localparam int IdxW  = 12;
`ifdef MEM_SRAM_ADAPTER_ECC_EN
  localparam int SramW = 39;
  localparam int LatP  = 2;
`else
  localparam int SramW = 32;
  localparam int LatP  = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  mem_h2d_t         mem_i;
  mem_d2h_t         mem_o;
  logic             sram_req_o, sram_we_o;
  logic [IdxW-1:0]  sram_addr_o;
  logic [SramW-1:0] sram_wdata_o, sram_wmask_o;
  logic [SramW-1:0] sram_rdata_i = '0;

  mem_sram_adapter #(.Depth(Depth)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mem_i        (mem_i),
    .mem_o        (mem_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_wmask_o (sram_wmask_o),
    .sram_rdata_i (sram_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro model
  logic [SramW-1:0] mem [Depth];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        mem[sram_addr_o] <= (mem[sram_addr_o] & ~sram_wmask_o) | (sram_wdata_o & sram_wmask_o);
        wr_cnt <= wr_cnt + 1;
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_rsp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every response against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && mem_o.valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("rsp %0d @%0d: data=%08h err=%02b (want %08h %02b @%0d)",
                 n_rsp, cyc, mem_o.data, mem_o.error, e.data, e.err, e.cyc);
        check("rsp_data", 64'(mem_o.data), 64'(e.data));
        check("rsp_err", 64'(mem_o.error), 64'(e.err));
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
        n_rsp++;
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge
  // (after the RMW cycle for lat==2).
  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] mask,
                       input logic [31:0] exp_data, input logic [1:0] exp_err, input int lat);
    int waits = 0;
    bit got = 0;
    mem_i.req  = 1'b1;
    mem_i.we   = we;
    mem_i.addr = addr;
    mem_i.data = data;
    mem_i.mask = mask;
    while (!got && waits < 8) begin
      @(negedge clk);
      if (mem_o.gnt) begin
        got = 1;
        if (addr >= Depth) check({name, "_no_sram_req"}, 64'(sram_req_o), 64'd0);
        exp_q.push_back('{exp_data, exp_err, cyc + lat});
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    check({name, "_gnt_wait"}, 64'(waits), 64'd0);
    mem_i.req = 1'b0;
    if (lat == 2) begin
      @(negedge clk);
      check({name, "_gnt_rmw"}, 64'(mem_o.gnt), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [SramW-1:0] saved;
    int saved_wc;
    int drain;
    for (int i = 0; i < Depth; i++) mem[i] = '0;
    mem_i = '0;
    // Active request during reset must not reach the macro.
    mem_i.req  = 1'b1;
    mem_i.we   = 1'b1;
    mem_i.addr = 32'd5;
    mem_i.data = 32'hFFFF_FFFF;
    mem_i.mask = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(mem_o.gnt), 64'd0);
    check("rst_valid", 64'(mem_o.valid), 64'd0);
    check("rst_data", 64'(mem_o.data), 64'd0);
    check("rst_error", 64'(mem_o.error), 64'd0);
    check("rst_sram_req", 64'(sram_req_o), 64'd0);
    check("rst_sram_we", 64'(sram_we_o), 64'd0);
    check("rst_sram_addr", 64'(sram_addr_o), 64'd0);
    check("rst_sram_wdata", 64'(sram_wdata_o), 64'd0);
    check("rst_sram_wmask", 64'(sram_wmask_o), 64'd0);
    @(posedge clk);
    #1;
    mem_i = '0;
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_gnt", 64'(mem_o.gnt), 64'd1);
    check("post_rst_wr_cnt", 64'(wr_cnt), 64'd0);
    @(posedge clk);
    #1;

    issue("wr5", 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1);
    issue("rd5", 1'b0, 32'd5, 32'h0, 4'hF, 32'hDEAD_BEEF, 2'b00, 1);

    for (int i = 0; i < 16; i++)
      issue("wr_seq", 1'b1, 32'(i), 32'hC0DE_0000 | 32'(i * 17), 4'hF, 32'h0, 2'b00, 1);
    for (int i = 0; i < 16; i++)
      issue("rd_seq", 1'b0, 32'(i), 32'h0, 4'hF, 32'hC0DE_0000 | 32'(i * 17), 2'b00, 1);

    issue("wr3", 1'b1, 32'd3, 32'h1234_5678, 4'hF, 32'h0, 2'b00, 1);
    issue("pw3", 1'b1, 32'd3, 32'h0000_AB00, 4'b0010, 32'h0, 2'b00, LatP);
    issue("rd3", 1'b0, 32'd3, 32'h0, 4'hF, 32'h1234_AB78, 2'b00, 1);

    saved_wc = wr_cnt;
    issue("rd_oor", 1'b0, 32'd4096, 32'h0, 4'hF, 32'h0, 2'b10, 1);
    issue("wr_oor", 1'b1, 32'd5000, 32'h5555_AAAA, 4'hF, 32'h0, 2'b10, 1);
    check("oor_no_write", 64'(wr_cnt), 64'(saved_wc));
    issue("rd_alias", 1'b0, 32'd904, 32'h0, 4'hF, 32'h0, 2'b00, 1);

`ifdef MEM_SRAM_ADAPTER_ECC_EN
    // Single-bit flip corrected on read; double flip reported raw.
    issue("wr7", 1'b1, 32'd7, 32'hA5A5_A5A5, 4'hF, 32'h0, 2'b00, 1);
    mem[7][7] = ~mem[7][7];
    issue("rd7_sec", 1'b0, 32'd7, 32'h0, 4'hF, 32'hA5A5_A5A5, 2'b01, 1);
    mem[7][20] = ~mem[7][20];
    issue("rd7_ded", 1'b0, 32'd7, 32'h0, 4'hF, 32'hA5B5_A525, 2'b10, 1);
    saved = mem[7];
    saved_wc = wr_cnt;
    issue("pw7_ded", 1'b1, 32'd7, 32'h0000_0011, 4'b0001, 32'h0, 2'b10, 2);
    check("pw7_word_kept", 64'(mem[7]), 64'(saved));
    check("pw7_no_write", 64'(wr_cnt), 64'(saved_wc));

    // Correctable RMW writes back the corrected, merged word.
    issue("wr8", 1'b1, 32'd8, 32'h0102_0304, 4'hF, 32'h0, 2'b00, 1);
    mem[8][3] = ~mem[8][3];
    issue("pw8_sec", 1'b1, 32'd8, 32'h7700_0000, 4'b1000, 32'h0, 2'b01, 2);
    issue("rd8", 1'b0, 32'd8, 32'h0, 4'hF, 32'h7702_0304, 2'b00, 1);

    // Reset during the RMW cycle drops the write and its response.
    issue("wr9", 1'b1, 32'd9, 32'h1234_5678, 4'hF, 32'h0, 2'b00, 1);
    saved = mem[9];
    mem_i.req  = 1'b1;
    mem_i.we   = 1'b1;
    mem_i.addr = 32'd9;
    mem_i.data = 32'h0000_00FF;
    mem_i.mask = 4'b0001;
    @(negedge clk);
    check("rmwrst_gnt", 64'(mem_o.gnt), 64'd1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    mem_i.req = 1'b0;
    saved_wc = wr_cnt;
    @(negedge clk);
    check("rmwrst_sram_req", 64'(sram_req_o), 64'd0);
    check("rmwrst_gnt_low", 64'(mem_o.gnt), 64'd0);
    @(posedge clk);
    #1;
    check("rmwrst_no_write", 64'(wr_cnt), 64'(saved_wc));
    check("rmwrst_word_kept", 64'(mem[9]), 64'(saved));
    check("rmwrst_no_valid", 64'(mem_o.valid), 64'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    issue("rd9", 1'b0, 32'd9, 32'h0, 4'hF, 32'h1234_5678, 2'b00, 1);
`endif

    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mem_sram_adapter
